// File: rtl/compute_cluster_mem.sv
// Sparse compute cluster with built-in read-only source SRAMs.
//
// IFM and filter chunk words are copied from the internal SRAMs into
// ping-pong chunk buffers, each word tagged with a per-byte sparsemap
// (byte != 0). A compute pass walks words 0..L of the selected buffers; every
// compute unit (CU) forms the dot product of the shared IFM word with its own
// filter word over bytes whose IFM and filter sparsemap bits are both set, and
// adds it into one of its accumulators.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   ifm_chunk_wr_*                  IFM word copy: valid, word index, buffer
//   ifm_sram_rd_count_i             IFM SRAM entry being copied
//   ifm_chunk_rd_sel_i              IFM buffer used by compute passes
//   fil_chunk_wr_*                  filter word copy: valid, word index, buffer
//   fil_chunk_cu_wr_sel_i           CU mask receiving the filter word
//   fil_sram_rd_count_i             filter SRAM entry being copied
//   fil_chunk_rd_sel_i              filter buffer used by compute passes
//   run_valid_i, total_chunk_start_i  pass start qualifier and request
//   rd_fil_sparsemap_last_i         last word index of the pass
//   acc_buf_sel_i                   accumulator targeted by the pass
//   total_chunk_end_o               one-cycle pass-done pulse
//   com_unit_out_buf_sel_i          CU whose accumulators are read back
//   out_buf_dat_o                   accumulators of that CU, acc0 in LSBs
module compute_cluster_mem #(
  parameter int unsigned BUS_SIZE         = 8,
  parameter int unsigned WR_DAT_CYC_NUM   = 4,
  parameter int unsigned SRAM_IFM_NUM     = 256,
  parameter int unsigned SRAM_FILTER_NUM  = 64,
  parameter int unsigned COMPUTE_UNIT_NUM = 4,
  parameter int unsigned OUTPUT_BUF_NUM   = 16,
  parameter int unsigned ACC_W            = 32,
  localparam int unsigned RD_DAT_CYC_NUM  = WR_DAT_CYC_NUM,
  localparam int unsigned OUTPUT_BUF_SIZE = OUTPUT_BUF_NUM * ACC_W,
  localparam int unsigned WORD_W          = BUS_SIZE * 8,
  localparam int unsigned WR_CNT_W  = (WR_DAT_CYC_NUM > 1) ? $clog2(WR_DAT_CYC_NUM) : 1,
  localparam int unsigned RD_CNT_W  = (RD_DAT_CYC_NUM > 1) ? $clog2(RD_DAT_CYC_NUM) : 1,
  localparam int unsigned IFM_AW    = (SRAM_IFM_NUM > 1) ? $clog2(SRAM_IFM_NUM) : 1,
  localparam int unsigned FIL_AW    = (SRAM_FILTER_NUM > 1) ? $clog2(SRAM_FILTER_NUM) : 1,
  localparam int unsigned CU_W      = (COMPUTE_UNIT_NUM > 1) ? $clog2(COMPUTE_UNIT_NUM) : 1,
  localparam int unsigned ACC_SEL_W = (OUTPUT_BUF_NUM > 1) ? $clog2(OUTPUT_BUF_NUM) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        ifm_chunk_wr_valid_i,
  input  logic [WR_CNT_W-1:0]         ifm_chunk_wr_count_i,
  input  logic                        ifm_chunk_wr_sel_i,
  input  logic                        ifm_chunk_rd_sel_i,
  input  logic [IFM_AW-1:0]           ifm_sram_rd_count_i,
  input  logic                        fil_chunk_wr_valid_i,
  input  logic [WR_CNT_W-1:0]         fil_chunk_wr_count_i,
  input  logic                        fil_chunk_wr_sel_i,
  input  logic                        fil_chunk_rd_sel_i,
  input  logic [COMPUTE_UNIT_NUM-1:0] fil_chunk_cu_wr_sel_i,
  input  logic [FIL_AW-1:0]           fil_sram_rd_count_i,
  input  logic                        run_valid_i,
  input  logic                        total_chunk_start_i,
  input  logic [RD_CNT_W-1:0]         rd_fil_sparsemap_last_i,
  input  logic [ACC_SEL_W-1:0]        acc_buf_sel_i,
  output logic                        total_chunk_end_o,
  input  logic [CU_W-1:0]             com_unit_out_buf_sel_i,
  output logic [OUTPUT_BUF_SIZE-1:0]  out_buf_dat_o
);

  // Behavioural SRAM contents: pure functions of entry and byte index.
  function automatic logic [7:0] ifm_byte(input logic [31:0] a, input logic [31:0] i);
    if ((a + i) % 32'd4 == 32'd0) return 8'h00;
    return 8'((a * 32'd3 + i) & 32'h7F);
  endfunction

  function automatic logic [7:0] fil_byte(input logic [31:0] a, input logic [31:0] i);
    if ((a + i) % 32'd3 == 32'd0) return 8'h00;
    return 8'((a + 32'd2 * i) & 32'h0F);
  endfunction

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  logic [WORD_W-1:0]   ifm_wr_word, fil_wr_word;
  logic [BUS_SIZE-1:0] ifm_wr_map, fil_wr_map;

  logic [WORD_W-1:0]   ifm_buf_q [2][WR_DAT_CYC_NUM];
  logic [BUS_SIZE-1:0] ifm_map_q [2][WR_DAT_CYC_NUM];
  logic [WORD_W-1:0]   fil_buf_q [COMPUTE_UNIT_NUM][2][WR_DAT_CYC_NUM];
  logic [BUS_SIZE-1:0] fil_map_q [COMPUTE_UNIT_NUM][2][WR_DAT_CYC_NUM];

  logic [ACC_W-1:0]    acc_q [COMPUTE_UNIT_NUM][OUTPUT_BUF_NUM];

  state_e               state_q, state_d;
  logic [RD_CNT_W-1:0]  cnt_q, cnt_d;
  logic [RD_CNT_W-1:0]  last_q, last_d;
  logic [ACC_SEL_W-1:0] acc_sel_q, acc_sel_d;
  logic                 end_q;
  logic                 proc_en, pass_done;

  logic [WORD_W-1:0]    ifm_rd_word;
  logic [BUS_SIZE-1:0]  ifm_rd_map;
  logic signed [15:0]   prod;
  logic [ACC_W-1:0]     dot [COMPUTE_UNIT_NUM];

  // SRAM read of the word being copied, with its sparsemap.
  always_comb begin
    ifm_wr_word = '0;
    ifm_wr_map  = '0;
    fil_wr_word = '0;
    fil_wr_map  = '0;
    for (int k = 0; k < BUS_SIZE; k++) begin
      ifm_wr_word[k*8 +: 8] = ifm_byte(32'(ifm_sram_rd_count_i),
                                       32'(ifm_chunk_wr_count_i) * BUS_SIZE + 32'(k));
      fil_wr_word[k*8 +: 8] = fil_byte(32'(fil_sram_rd_count_i),
                                       32'(fil_chunk_wr_count_i) * BUS_SIZE + 32'(k));
      ifm_wr_map[k] = |ifm_wr_word[k*8 +: 8];
      fil_wr_map[k] = |fil_wr_word[k*8 +: 8];
    end
  end

  // Chunk buffers: writes are unconditional on pass state; a pass reading the
  // buffer being written simply sees the new data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < WR_DAT_CYC_NUM; w++) begin
          ifm_buf_q[b][w] <= '0;
          ifm_map_q[b][w] <= '0;
          for (int c = 0; c < COMPUTE_UNIT_NUM; c++) begin
            fil_buf_q[c][b][w] <= '0;
            fil_map_q[c][b][w] <= '0;
          end
        end
      end
    end else begin
      if (ifm_chunk_wr_valid_i) begin
        ifm_buf_q[ifm_chunk_wr_sel_i][ifm_chunk_wr_count_i] <= ifm_wr_word;
        ifm_map_q[ifm_chunk_wr_sel_i][ifm_chunk_wr_count_i] <= ifm_wr_map;
      end
      for (int c = 0; c < COMPUTE_UNIT_NUM; c++) begin
        if (fil_chunk_wr_valid_i && fil_chunk_cu_wr_sel_i[c]) begin
          fil_buf_q[c][fil_chunk_wr_sel_i][fil_chunk_wr_count_i] <= fil_wr_word;
          fil_map_q[c][fil_chunk_wr_sel_i][fil_chunk_wr_count_i] <= fil_wr_map;
        end
      end
    end
  end

  // Pass control: state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_q    <= '0;
      acc_sel_q <= '0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      acc_sel_q <= acc_sel_d;
      end_q     <= pass_done;
    end
  end

  // Pass control: next state. Starts are only looked at while idle, so a
  // start during the end-pulse cycle is accepted.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    acc_sel_d = acc_sel_q;
    unique case (state_q)
      StIdle: begin
        if (total_chunk_start_i && run_valid_i) begin
          state_d   = StRun;
          cnt_d     = '0;
          last_d    = rd_fil_sparsemap_last_i;
          acc_sel_d = acc_buf_sel_i;
        end
      end
      StRun: begin
        if (cnt_q == last_q) state_d = StIdle;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Pass control: outputs.
  always_comb begin
    proc_en   = (state_q == StRun);
    pass_done = proc_en && (cnt_q == last_q);
  end

  assign total_chunk_end_o = end_q;

  assign ifm_rd_word = ifm_buf_q[ifm_chunk_rd_sel_i][cnt_q];
  assign ifm_rd_map  = ifm_map_q[ifm_chunk_rd_sel_i][cnt_q];

  // Per-CU sparse dot product of the current word, sign-extended to ACC_W.
  always_comb begin
    prod = '0;
    for (int c = 0; c < COMPUTE_UNIT_NUM; c++) begin
      dot[c] = '0;
      for (int k = 0; k < BUS_SIZE; k++) begin
        if (ifm_rd_map[k] && fil_map_q[c][fil_chunk_rd_sel_i][cnt_q][k]) begin
          prod = $signed(ifm_rd_word[k*8 +: 8]) *
                 $signed(fil_buf_q[c][fil_chunk_rd_sel_i][cnt_q][k*8 +: 8]);
          dot[c] = dot[c] + {{(ACC_W-16){prod[15]}}, prod};
        end
      end
    end
  end

  // Accumulators only ever add (wrapping); reset is the only clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < COMPUTE_UNIT_NUM; c++) begin
        for (int n = 0; n < OUTPUT_BUF_NUM; n++) begin
          acc_q[c][n] <= '0;
        end
      end
    end else if (proc_en) begin
      for (int c = 0; c < COMPUTE_UNIT_NUM; c++) begin
        acc_q[c][acc_sel_q] <= acc_q[c][acc_sel_q] + dot[c];
      end
    end
  end

  // Readback mux; a select with no matching CU yields zero.
  always_comb begin
    out_buf_dat_o = '0;
    for (int c = 0; c < COMPUTE_UNIT_NUM; c++) begin
      if (com_unit_out_buf_sel_i == CU_W'(c)) begin
        for (int n = 0; n < OUTPUT_BUF_NUM; n++) begin
          out_buf_dat_o[n*ACC_W +: ACC_W] = acc_q[c][n];
        end
      end
    end
  end

endmodule

// File: tb/tb_compute_cluster_mem.sv
// Scoreboard bench for compute_cluster_mem: each pass pushes its expected
// accumulator value; a forked monitor pops and compares on every end pulse.
module tb_compute_cluster_mem;
  localparam int ACC_W = 32;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         ifm_wr_valid, ifm_wr_sel, ifm_rd_sel;
  logic [1:0]   ifm_wr_count;
  logic [7:0]   ifm_sram;
  logic         fil_wr_valid, fil_wr_sel, fil_rd_sel;
  logic [1:0]   fil_wr_count;
  logic [3:0]   fil_cu_mask;
  logic [5:0]   fil_sram;
  logic         run_valid, start;
  logic [1:0]   last;
  logic [3:0]   acc_sel;
  logic         end_o;
  logic [1:0]   cu_sel;
  logic [511:0] out_dat;

  typedef struct {
    int          cu;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   end_cnt = 0;

  always #5 clk = ~clk;

  compute_cluster_mem dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .ifm_chunk_wr_valid_i   (ifm_wr_valid),
    .ifm_chunk_wr_count_i   (ifm_wr_count),
    .ifm_chunk_wr_sel_i     (ifm_wr_sel),
    .ifm_chunk_rd_sel_i     (ifm_rd_sel),
    .ifm_sram_rd_count_i    (ifm_sram),
    .fil_chunk_wr_valid_i   (fil_wr_valid),
    .fil_chunk_wr_count_i   (fil_wr_count),
    .fil_chunk_wr_sel_i     (fil_wr_sel),
    .fil_chunk_rd_sel_i     (fil_rd_sel),
    .fil_chunk_cu_wr_sel_i  (fil_cu_mask),
    .fil_sram_rd_count_i    (fil_sram),
    .run_valid_i            (run_valid),
    .total_chunk_start_i    (start),
    .rd_fil_sparsemap_last_i(last),
    .acc_buf_sel_i          (acc_sel),
    .total_chunk_end_o      (end_o),
    .com_unit_out_buf_sel_i (cu_sel),
    .out_buf_dat_o          (out_dat)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && end_o) begin
        end_cnt++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_end: got end pulse, expected none");
        end else begin
          e = sb.pop_front();
          check($sformatf("pass_result cu%0d acc%0d", e.cu, e.idx),
                out_dat[e.idx*ACC_W +: ACC_W], e.val);
        end
      end
    end
  endtask

  task automatic load_ifm(input logic b, input int entry, input int word);
    ifm_wr_valid = 1'b1;
    ifm_wr_sel   = b;
    ifm_sram     = 8'(entry);
    ifm_wr_count = 2'(word);
    @(posedge clk); #1;
    ifm_wr_valid = 1'b0;
  endtask

  task automatic load_fil(input logic b, input int entry, input int word, input logic [3:0] m);
    fil_wr_valid = 1'b1;
    fil_wr_sel   = b;
    fil_sram     = 6'(entry);
    fil_wr_count = 2'(word);
    fil_cu_mask  = m;
    @(posedge clk); #1;
    fil_wr_valid = 1'b0;
  endtask

  // Counts edges until the end pulse, then checks it lasts one cycle.
  task automatic wait_end(input int exp_cyc, input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (end_o) begin
        n = i;
        break;
      end
    end
    check({name, "_latency"}, n, exp_cyc);
    @(posedge clk); #1;
    check({name, "_width"}, {31'd0, end_o}, 0);
  endtask

  task automatic do_pass(input int l, input int acc, input int cu, input logic [31:0] val);
    sb.push_back('{cu: cu, idx: acc, val: val});
    cu_sel    = 2'(cu);
    last      = 2'(l);
    acc_sel   = 4'(acc);
    run_valid = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    wait_end(l + 1, $sformatf("pass acc%0d", acc));
  endtask

  task automatic check_acc(input string name, input int cu, input int idx, input logic [31:0] v);
    cu_sel = 2'(cu);
    #1;
    check(name, out_dat[idx*ACC_W +: ACC_W], v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int ec;
    rst_i = 1'b1;
    ifm_wr_valid = 0; ifm_wr_sel = 0; ifm_rd_sel = 0; ifm_wr_count = 0; ifm_sram = 0;
    fil_wr_valid = 0; fil_wr_sel = 0; fil_rd_sel = 0; fil_wr_count = 0; fil_sram = 0;
    fil_cu_mask = 0; run_valid = 0; start = 0; last = 0; acc_sel = 0; cu_sel = 0;
    fork
      monitor_loop();
    join_none
    idle(3);
    rst_i = 1'b0;
    idle(1);

    check("reset_end", {31'd0, end_o}, 0);
    for (int c = 0; c < 4; c++) begin
      cu_sel = 2'(c);
      #1;
      check($sformatf("reset_zero cu%0d", c), {31'd0, out_dat == '0}, 1);
    end

    // IFM entry 1 word 0 . filter entry 0 word 0 = 4*2+5*4+7*8+8*10 = 164.
    load_ifm(0, 1, 0);
    load_fil(0, 0, 0, 4'b0001);
    do_pass(0, 0, 0, 164);
    for (int c = 1; c < 4; c++) check_acc($sformatf("cu%0d_acc0_untouched", c), c, 0, 0);
    do_pass(0, 0, 0, 328);
    do_pass(0, 5, 0, 164);
    check_acc("cu0_acc0_after_acc5", 0, 0, 328);

    // Broadcast filter to all CUs.
    load_fil(0, 0, 0, 4'hF);
    do_pass(0, 1, 0, 164);
    for (int c = 1; c < 4; c++) check_acc($sformatf("cu%0d_acc1", c), c, 1, 164);

    // Ping-pong: fill buffer 1 (IFM entry 0 word 0) while computing on buffer 0.
    sb.push_back('{cu: 0, idx: 2, val: 164});
    cu_sel = 0; last = 0; acc_sel = 2; run_valid = 1; start = 1;
    ifm_wr_valid = 1; ifm_wr_sel = 1; ifm_sram = 0; ifm_wr_count = 0;
    @(posedge clk); #1;
    start = 0; ifm_wr_valid = 0;
    fil_wr_valid = 1; fil_wr_sel = 1; fil_sram = 0; fil_wr_count = 0; fil_cu_mask = 4'hF;
    wait_end(1, "pingpong");
    fil_wr_valid = 0;
    // Buffer 1: 1*2+2*4+5*10+7*14 = 158.
    ifm_rd_sel = 1; fil_rd_sel = 1;
    do_pass(0, 3, 0, 158);
    check_acc("cu2_acc3_buf1", 2, 3, 158);
    ifm_rd_sel = 0; fil_rd_sel = 0;

    // Full four-word chunk: 164+416+524+740 = 1844.
    for (int w = 1; w < 4; w++) begin
      load_ifm(0, 1, w);
      load_fil(0, 0, w, 4'hF);
    end

    // Start held while busy, run_valid dropped mid-pass.
    ec = end_cnt;
    sb.push_back('{cu: 0, idx: 4, val: 1844});
    cu_sel = 0; last = 3; acc_sel = 4; run_valid = 1; start = 1;
    idle(3);
    start = 0; run_valid = 0;
    wait_end(2, "busy_start");
    idle(6);
    check("busy_start_single_end", end_cnt - ec, 1);
    check_acc("cu3_acc4", 3, 4, 1844);

    // Back-to-back: second start coincides with the first end pulse.
    sb.push_back('{cu: 0, idx: 6, val: 1844});
    cu_sel = 0; last = 3; acc_sel = 6; run_valid = 1; start = 1;
    @(posedge clk); #1;
    start = 0;
    ec = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (end_o) begin
        ec = i;
        break;
      end
    end
    check("b2b_first_latency", ec, 4);
    sb.push_back('{cu: 0, idx: 7, val: 164});
    last = 0; acc_sel = 7; start = 1;
    @(posedge clk); #1;
    start = 0;
    check("b2b_first_width", {31'd0, end_o}, 0);
    wait_end(1, "b2b_second");

    // Start without run_valid is ignored.
    ec = end_cnt;
    run_valid = 0; start = 1;
    idle(1);
    start = 0;
    idle(6);
    check("no_run_valid_no_end", end_cnt - ec, 0);

    // Reset mid-pass: no end pulse, accumulators cleared.
    ec = end_cnt;
    last = 3; acc_sel = 8; run_valid = 1; start = 1;
    idle(1);
    start = 0;
    idle(2);
    rst_i = 1;
    idle(1);
    rst_i = 0;
    idle(6);
    check("reset_midpass_no_end", end_cnt - ec, 0);
    for (int c = 0; c < 4; c++) begin
      cu_sel = 2'(c);
      #1;
      check($sformatf("reset_midpass_zero cu%0d", c), {31'd0, out_dat == '0}, 1);
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
